// File: rtl/wr_line_buf_pkg.sv
// ---------------------------------------------------------------------------
// wr_line_buf_pkg
// Shared definitions for the DDR-side line buffers: the write-side FSM state
// type and the line-geometry helpers, which the read-side buffer also uses.
// ---------------------------------------------------------------------------
package wr_line_buf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } wr_state_t;

    // Number of 128-bit input words that carry one line of pixels.
    function automatic int calc_line_words(input int h_num, input int pix_width);
        return (h_num * pix_width) / 128;
    endfunction

    // Number of DDR beats (8*DQ_WIDTH bits each) that carry one line.
    function automatic int calc_line_beats(input int line_words, input int dq_width);
        return (line_words * 128) / (8 * dq_width);
    endfunction

    // Address distance between consecutive lines in a frame bank.
    function automatic int calc_line_step(input int line_beats);
        return line_beats * 8;
    endfunction

endpackage

// File: rtl/wr_line_fifo.sv
// ---------------------------------------------------------------------------
// wr_line_fifo
// Single-clock FIFO of 2^AW entries of DW bits with a registered read port.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   flush            empties the FIFO (pointers and level cleared)
//   wr_en, wr_data   write request; ignored while full or flushing
//   rd_en            read request; rd_data updates on the following edge,
//                    to zero when the FIFO is empty (pointer does not move)
//   rd_data          registered read data
//   level            number of stored entries
//   full, empty      status flags derived from level
// ---------------------------------------------------------------------------
module wr_line_fifo #(
    parameter int AW = 9,
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH = (AW + 1)'(1 << AW);

    logic [DW-1:0] mem [0:(1 << AW) - 1];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_wr;
    logic          do_rd;

    assign full  = (level == DEPTH);
    assign empty = (level == '0);
    assign do_wr = wr_en && !full && !flush;
    assign do_rd = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wr_data;
        end
    end

    // Simultaneous write and read both happen, leaving the level unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (rd_en) begin
                rd_data <= empty ? '0 : mem[rptr];
            end
            if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (do_wr) begin
                    wptr <= wptr + 1'b1;
                end
                if (do_rd) begin
                    rptr <= rptr + 1'b1;
                end
                level <= level + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);
            end
        end
    end

endmodule

// File: rtl/wr_line_buf.sv
// ---------------------------------------------------------------------------
// wr_line_buf
// DDR write-side line buffer. Packs pairs of 128-bit pixel words into DDR
// beats, buffers them in a FIFO and issues one write burst per complete
// line into ping-pong frame banks selected by frame_cnt[0].
// Ports:
//   ddr_clk, ddr_rst    clock and asynchronous active-high reset
//   wr_fsync            frame sync, rising edge restarts the frame
//   in_valid/in_ready/in_data   128-bit input word stream
//   ddr_wreq/ddr_wrdy   burst request handshake
//   ddr_waddr, ddr_wr_len       burst start address and length in beats
//   ddr_wdata_req/ddr_wdata     beat pull, data one cycle after request
//   ddr_wdone           burst complete (rising edge used)
// Optional (macro WR_LINE_BUF_STAT_EN):
//   err_underflow       sticky FIFO underflow flag, cleared by a restart
//   lines_done          lines written in the current frame
// ---------------------------------------------------------------------------
module wr_line_buf
    import wr_line_buf_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 27,
    parameter logic [31:0] ADDR_OFFSET     = 32'h0000_0000,
    parameter int          H_NUM           = 1920,
    parameter int          V_NUM           = 1080,
    parameter int          DQ_WIDTH        = 32,
    parameter int          LEN_WIDTH       = 16,
    parameter int          PIX_WIDTH       = 24,
    parameter int          LINE_ADDR_WIDTH = 19,
    parameter int          FRAME_CNT_WIDTH = 8,
    parameter int          FIFO_AW         = 9
) (
    input  logic                    ddr_clk,
    input  logic                    ddr_rst,
    input  logic                    wr_fsync,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            in_data,
    output logic                    ddr_wreq,
    output logic [ADDR_WIDTH-1:0]   ddr_waddr,
    output logic [LEN_WIDTH-1:0]    ddr_wr_len,
    input  logic                    ddr_wrdy,
    input  logic                    ddr_wdata_req,
    output logic [8*DQ_WIDTH-1:0]   ddr_wdata,
    input  logic                    ddr_wdone
`ifdef WR_LINE_BUF_STAT_EN
    ,
    output logic                    err_underflow,
    output logic [11:0]             lines_done
`endif
);

    localparam int LINE_WORDS = calc_line_words(H_NUM, PIX_WIDTH);
    localparam int LINE_BEATS = calc_line_beats(LINE_WORDS, DQ_WIDTH);
    localparam int LINE_STEP  = calc_line_step(LINE_BEATS);
    localparam int BEAT_W     = 8 * DQ_WIDTH;
    localparam int LCNT_W     = $clog2(V_NUM + 1);

    localparam logic [FIFO_AW:0]         BEATS_THR = (FIFO_AW + 1)'(LINE_BEATS);
    localparam logic [LCNT_W-1:0]        LINES_MAX = LCNT_W'(V_NUM);
    localparam logic [LINE_ADDR_WIDTH-1:0] STEP_INC = LINE_ADDR_WIDTH'(LINE_STEP);

    wr_state_t                  state;
    logic                       wreq_q;
    logic                       fsync_q1;
    logic                       fsync_q2;
    logic                       wdone_q;
    logic                       restart_pending;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
    logic [LINE_ADDR_WIDTH-1:0] line_addr;
    logic [LCNT_W-1:0]          line_cnt;
    logic                       hold_valid;
    logic [127:0]               hold_word;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [FIFO_AW:0]           fifo_level;
    logic                       fsync_rise;
    logic                       wdone_rise;
    logic                       restart_now;
    logic                       accept;
    logic                       fifo_wr;
    logic                       unused_frame_bits;

    assign fsync_rise  = fsync_q1 && !fsync_q2;
    assign wdone_rise  = ddr_wdone && !wdone_q;
    // A restart only runs from IDLE; one requested mid-burst waits there.
    assign restart_now = (state == IDLE) && (restart_pending || fsync_rise);

    assign in_ready = !ddr_rst && !fifo_full && !restart_pending;
    assign accept   = in_valid && in_ready;
    assign fifo_wr  = accept && hold_valid;

    assign ddr_wreq   = wreq_q;
    assign ddr_wr_len = LEN_WIDTH'(LINE_BEATS);
    assign ddr_waddr  = ADDR_WIDTH'({frame_cnt[0], line_addr}) + ADDR_WIDTH'(ADDR_OFFSET);

    assign unused_frame_bits = ^frame_cnt[FRAME_CNT_WIDTH-1:1];

    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            fsync_q1 <= 1'b0;
            fsync_q2 <= 1'b0;
            wdone_q  <= 1'b0;
        end else begin
            fsync_q1 <= wr_fsync;
            fsync_q2 <= fsync_q1;
            wdone_q  <= ddr_wdone;
        end
    end

    // Packer: first word of a pair is held, second completes the beat.
    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            hold_valid <= 1'b0;
            hold_word  <= '0;
        end else if (restart_now) begin
            hold_valid <= 1'b0;
        end else if (accept) begin
            if (!hold_valid) begin
                hold_word  <= in_data;
                hold_valid <= 1'b1;
            end else begin
                hold_valid <= 1'b0;
            end
        end
    end

    // Burst FSM plus frame/line bookkeeping.
    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            state           <= IDLE;
            wreq_q          <= 1'b0;
            restart_pending <= 1'b0;
            frame_cnt       <= '0;
            line_cnt        <= '0;
            line_addr       <= '0;
        end else begin
            if (restart_now) begin
                frame_cnt       <= frame_cnt + 1'b1;
                line_cnt        <= '0;
                line_addr       <= '0;
                restart_pending <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!restart_now && (fifo_level >= BEATS_THR) && (line_cnt < LINES_MAX)) begin
                        state  <= REQ;
                        wreq_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (fsync_rise) begin
                        restart_pending <= 1'b1;
                    end
                    if (ddr_wrdy) begin
                        state  <= DATA;
                        wreq_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (fsync_rise) begin
                        restart_pending <= 1'b1;
                    end
                    if (wdone_rise) begin
                        state     <= IDLE;
                        line_cnt  <= line_cnt + 1'b1;
                        line_addr <= line_addr + STEP_INC;
                    end
                end
                default: begin
                    state  <= IDLE;
                    wreq_q <= 1'b0;
                end
            endcase
        end
    end

    wr_line_fifo #(
        .AW (FIFO_AW),
        .DW (BEAT_W)
    ) u_fifo (
        .clk     (ddr_clk),
        .rst     (ddr_rst),
        .flush   (restart_now),
        .wr_en   (fifo_wr),
        .wr_data (BEAT_W'({in_data, hold_word})),
        .rd_en   (ddr_wdata_req),
        .rd_data (ddr_wdata),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef WR_LINE_BUF_STAT_EN
    logic err_q;

    always_ff @(posedge ddr_clk or posedge ddr_rst) begin
        if (ddr_rst) begin
            err_q <= 1'b0;
        end else if (restart_now) begin
            err_q <= 1'b0;
        end else if (ddr_wdata_req && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_underflow = err_q;
    assign lines_done    = 12'(line_cnt);
`endif

endmodule
